// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a req/ready handshake with WAIT_CYCLES wait states.
// Optional macro DMEM_ALIGN_CHECK_EN: flag misaligned/out-of-range accesses on err.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [3:0]    cnt_r, cnt_nxt_s;
  logic [31:0]   addr_r, wdata_r;
  logic          we_r;
  logic [31:0]   mem_r [DEPTH];
  logic [31:0]   rdata_r;
  logic          ready_r, err_r;

  logic [31:0]   acc_addr_s, acc_wdata_s;
  logic          acc_we_s;
  logic [AW-1:0] acc_idx_s;
  logic          oor_s, bad_s, err_s, enter_resp_s, capture_s;

  // Next-state and wait counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          capture_s   = 1'b1;
          cnt_nxt_s   = WAIT_LD;
          state_nxt_s = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // With zero wait states the access completes on the capture edge, so use live inputs in IDLE.
  always_comb begin
    acc_addr_s   = (state_r == ST_IDLE) ? addr  : addr_r;
    acc_wdata_s  = (state_r == ST_IDLE) ? wdata : wdata_r;
    acc_we_s     = (state_r == ST_IDLE) ? we    : we_r;
    acc_idx_s    = acc_addr_s[AW+1:2];
    oor_s        = (acc_addr_s >= 32'(DEPTH * 4));
`ifdef DMEM_ALIGN_CHECK_EN
    bad_s        = oor_s | (acc_addr_s[1:0] != 2'b00);
    err_s        = bad_s;
`else
    bad_s        = oor_s;
    err_s        = 1'b0;
`endif
    enter_resp_s = rst_n && (state_nxt_s == ST_RESP);
  end

  // Control state, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
      we_r    <= 1'b0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (capture_s) begin
        addr_r  <= addr;
        wdata_r <= wdata;
        we_r    <= we;
      end
      ready_r <= enter_resp_s;
      err_r   <= enter_resp_s & err_s;
      if (enter_resp_s) begin
        if (bad_s) begin
          rdata_r <= 32'h0;
        end else if (!acc_we_s) begin
          rdata_r <= mem_r[acc_idx_s];
        end
      end
    end
  end

  // RAM array: not reset, written only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (enter_resp_s && acc_we_s && !bad_s) begin
      mem_r[acc_idx_s] <= acc_wdata_s;
    end
  end

  assign rdata = rdata_r;
  assign ready = ready_r;
  assign err   = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic req, we, ready, err;
  logic [31:0] addr, wdata, rdata;
  logic req0, we0, ready0, err0;
  logic [31:0] addr0, wdata0, rdata0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_vld [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: a flat word array; errors and range decided from the byte address arithmetic.
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] exp_rd, output logic exp_e, output bit chk_rd);
    bit oor, mis, bad;
    int idx;
    oor    = (a >= 32'(DEPTH * 4));
    mis    = (a % 4) != 0;
    bad    = oor || (ALIGN_EN && mis);
    idx    = int'((a / 4) % DEPTH);
    exp_e  = ALIGN_EN && bad;
    exp_rd = 32'h0;
    chk_rd = 1'b0;
    if (bad) begin
      chk_rd = !w || ALIGN_EN;
    end else if (w) begin
      mdl_mem[idx] = d;
      mdl_vld[idx] = 1'b1;
    end else begin
      exp_rd = mdl_mem[idx];
      chk_rd = mdl_vld[idx];
    end
  endfunction

  // One handshake: latency counted in rising edges from driving req, then a one-cycle pulse check.
  task automatic access(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit drop_early, output logic [31:0] rd, output logic e);
    int lat;
    logic rdy;
    lat = 0;
    rdy = 1'b0;
    if (sel) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else     begin req  = 1'b1; we  = w; addr  = a; wdata  = d; end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (drop_early) begin req = 1'b0; req0 = 1'b0; end
      rdy = sel ? ready0 : ready;
      if (rdy) break;
    end
    rd = sel ? rdata0 : rdata;
    e  = sel ? err0 : err;
    req = 1'b0;
    req0 = 1'b0;
    chk(sel ? "latency_wc0" : "latency_wc2", 32'(lat), sel ? 32'd1 : 32'd3);
    @(negedge clk);
    chk("ready_single_pulse", {31'h0, sel ? ready0 : ready}, 32'h0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_e;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] rd, exp_rd;
    logic e, exp_e;
    bit chk_rd;
    int pulses, consec;
    logic prev_rdy;

    tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0,     32'h0,        1'b0};
    tbl[1] = '{1'b0, 32'h10,  32'h0,        1'b1,     32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h20,  32'hA5A5A5A5, 1'b0,     32'h0,        1'b0};
    tbl[3] = '{1'b1, 32'h100, 32'h0,        ALIGN_EN, 32'h0,        ALIGN_EN};
    tbl[4] = '{1'b0, 32'h20,  32'h0,        1'b1,     32'hA5A5A5A5, 1'b0};
    tbl[5] = '{1'b0, 32'h100, 32'h0,        1'b1,     32'h0,        ALIGN_EN};
    tbl[6] = '{1'b1, 32'h21,  32'h0BADF00D, ALIGN_EN, 32'h0,        ALIGN_EN};
    tbl[7] = '{1'b0, 32'h20,  32'h0,        1'b1,     ALIGN_EN ? 32'hA5A5A5A5 : 32'h0BADF00D, 1'b0};
    tbl[8] = '{1'b1, 32'hFC,  32'h600DCAFE, 1'b0,     32'h0,        1'b0};
    tbl[9] = '{1'b0, 32'hFC,  32'h0,        1'b1,     32'h600DCAFE, 1'b0};

    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_ready_wc0", {31'h0, ready0}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].d, exp_rd, exp_e, chk_rd);
      access(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, rd, e);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'h0, e}, {31'h0, tbl[i].exp_e});
    end

    // Zero wait states: held req yields one access every two cycles.
    access(1'b1, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, rd, e);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    pulses = 0; consec = 0; prev_rdy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready0) begin
        pulses++;
        chk("b2b_rdata", rdata0, 32'hCAFEF00D);
      end
      if (ready0 && prev_rdy) consec++;
      prev_rdy = ready0;
    end
    req0 = 1'b0;
    @(negedge clk);
    chk("b2b_pulses", 32'(pulses), 32'd6);
    chk("b2b_consecutive", 32'(consec), 32'd0);

    // req dropped during WAIT: access still completes.
    model(1'b1, 32'h20, 32'h12345678, exp_rd, exp_e, chk_rd);
    access(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b1, rd, e);
    model(1'b0, 32'h20, 32'h0, exp_rd, exp_e, chk_rd);
    access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, rd, e);
    chk("drop_req_rdata", rd, 32'h12345678);

    // Reset in WAIT loses the pending write.
    model(1'b1, 32'h30, 32'h11112222, exp_rd, exp_e, chk_rd);
    access(1'b0, 1'b1, 32'h30, 32'h11112222, 1'b0, rd, e);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h99998888;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", {31'h0, ready}, 32'h0);
    chk("rst_mid_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("rst_no_late_ready", 32'(pulses), 32'd0);
    access(1'b0, 1'b0, 32'h30, 32'h0, 1'b0, rd, e);
    chk("rst_lost_write", rd, 32'h11112222);

    // Randomised accesses against the model.
    for (int i = 0; i < 150; i++) begin
      logic w;
      logic [31:0] a, d;
      int kind;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      kind = $urandom_range(0, 9);
      if (kind <= 6)      a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      else if (kind == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (kind == 8) a = 32'($urandom_range(DEPTH * 4, 4095));
      else                a = $urandom | 32'h8000_0000;
      model(w, a, d, exp_rd, exp_e, chk_rd);
      access(1'b0, w, a, d, 1'b0, rd, e);
      if (chk_rd) chk($sformatf("rand%0d_rdata@%h", i, a), rd, exp_rd);
      chk($sformatf("rand%0d_err@%h", i, a), {31'h0, e}, {31'h0, exp_e});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
